// File: rtl/wpc_pkg.sv
// -----------------------------------------------------------------------------
// wpc_pkg
//   Shared definitions for the word-pack compressor: the 2-bit word tags and
//   the mapping from a tag to the number of high-order bytes that are kept.
// -----------------------------------------------------------------------------
package wpc_pkg;

  typedef logic [1:0] tag_t;   // per-word significance tag
  typedef logic [2:0] len_t;   // kept byte count for one word (0,1,2,4)

  localparam tag_t TAG_ZERO = 2'b00;  // whole word zero, nothing kept
  localparam tag_t TAG_B1   = 2'b01;  // only byte 3 significant
  localparam tag_t TAG_B2   = 2'b10;  // bytes 3..2 significant
  localparam tag_t TAG_FULL = 2'b11;  // all four bytes kept

  localparam len_t LEN_FULL = 3'd4;

  function automatic len_t tag_to_len(input tag_t tag);
    case (tag)
      TAG_ZERO: return 3'd0;
      TAG_B1:   return 3'd1;
      TAG_B2:   return 3'd2;
      default:  return LEN_FULL;
    endcase
  endfunction

endpackage

// File: rtl/word_classifier.sv
// -----------------------------------------------------------------------------
// word_classifier
//   Classifies one 32-bit word by how many of its high-order bytes must be
//   kept; the remaining low-order bytes are all zero and are dropped.
// Ports
//   i_word  in   32  word to classify
//   o_tag   out  2   significance tag (TAG_ZERO/TAG_B1/TAG_B2/TAG_FULL)
//   o_len   out  3   kept byte count for that tag (0/1/2/4)
// -----------------------------------------------------------------------------
module word_classifier
  import wpc_pkg::*;
(
  input  logic [31:0] i_word,
  output tag_t        o_tag,
  output len_t        o_len
);

  // The tests are ordered from the most to the least compressible case, so
  // the first match is always the shortest legal encoding.
  always_comb begin
    o_tag = TAG_FULL;
    if (i_word == 32'h0) begin
      o_tag = TAG_ZERO;
    end else if (i_word[23:0] == 24'h0) begin
      o_tag = TAG_B1;
    end else if (i_word[15:0] == 16'h0) begin
      o_tag = TAG_B2;
    end
    o_len = tag_to_len(o_tag);
  end

endmodule

// File: rtl/word_pack_compressor.sv
// -----------------------------------------------------------------------------
// word_pack_compressor
//   Streaming significance compressor. Each input line of NUM_WORDS 32-bit
//   words is classified word by word; the retained high-order bytes of every
//   word are packed contiguously (ascending word order) into out_data, with
//   the per-word tags and the total byte count alongside. Two pipeline stages
//   with valid/ready handshakes at both ends, one line per cycle throughput.
// Ports
//   clk         in   1            clock, rising edge
//   reset       in   1            asynchronous active-high reset
//   in_valid    in   1            input line valid
//   in_ready    out  1            line accepted this cycle when in_valid
//   in_data     in   LW           input line, word i = in_data[32*i +: 32]
//   in_bypass   in   1            pass line through uncompressed
//   out_valid   out  1            packed line valid
//   out_ready   in   1            downstream accepts packed line
//   out_data    out  LW           packed bytes, byte 0 at [7:0], zero above count
//   out_tag     out  2*NUM_WORDS  tag of word i at out_tag[2*i +: 2]
//   out_count   out  CNT_W        number of valid bytes in out_data
//   stat_clr    in   1            synchronous clear of the statistics
//   stat_lines  out  STAT_W       saturating count of emitted lines
//   stat_bytes  out  STAT_W       saturating sum of out_count over emitted lines
// -----------------------------------------------------------------------------
module word_pack_compressor
  import wpc_pkg::*;
#(
  parameter  int NUM_WORDS = 8,
  parameter  int STAT_W    = 32,
  localparam int LW        = 32 * NUM_WORDS,
  localparam int CNT_W     = $clog2(4 * NUM_WORDS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LW-1:0]          in_data,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LW-1:0]          out_data,
  output logic [2*NUM_WORDS-1:0] out_tag,
  output logic [CNT_W-1:0]       out_count,
  input  logic                   stat_clr,
  output logic [STAT_W-1:0]      stat_lines,
  output logic [STAT_W-1:0]      stat_bytes
);

  // ---------------------------------------------------------------------------
  // Handshake / stage enables
  // ---------------------------------------------------------------------------
  logic w_s2_en;
  logic w_s1_en;
  logic w_accept;
  logic w_emit;

  logic r_s1_valid;
  logic r_out_valid;

  // S2 may load when it is empty or its content leaves this cycle; S1 may
  // load when it is empty or hands its content to S2. This lets an S1 bubble
  // fill even while the output is stalled.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;
  assign w_accept = in_valid && w_s1_en;
  assign w_emit   = r_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 0 (combinational): classify words and compute byte offsets
  // ---------------------------------------------------------------------------
  tag_t                     w_cls_tag [NUM_WORDS];
  len_t                     w_cls_len [NUM_WORDS];
  logic [2*NUM_WORDS-1:0]   w_tag_vec;
  logic [3*NUM_WORDS-1:0]   w_len_vec;
  logic [CNT_W*NUM_WORDS-1:0] w_off_vec;
  logic [CNT_W-1:0]         w_run;
  logic [CNT_W-1:0]         w_count;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_cls
    word_classifier u_cls (
      .i_word (in_data[32*gi +: 32]),
      .o_tag  (w_cls_tag[gi]),
      .o_len  (w_cls_len[gi])
    );

    // Bypass forces every word to full length; the packer then reproduces
    // the input unchanged and the count comes out as 4*NUM_WORDS.
    assign w_tag_vec[2*gi +: 2] = in_bypass ? TAG_FULL : w_cls_tag[gi];
    assign w_len_vec[3*gi +: 3] = in_bypass ? LEN_FULL : w_cls_len[gi];
  end : g_cls

  // Exclusive prefix sum of the kept lengths: word i starts at the byte just
  // after everything kept from words 0..i-1. The final sum is the line count.
  always_comb begin : p_prefix
    w_run     = '0;
    w_off_vec = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_off_vec[CNT_W*i +: CNT_W] = w_run;
      w_run = w_run + CNT_W'(w_len_vec[3*i +: 3]);
    end
    w_count = w_run;
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic [LW-1:0]              r_s1_data;
  logic [2*NUM_WORDS-1:0]     r_s1_tag;
  logic [3*NUM_WORDS-1:0]     r_s1_len;
  logic [CNT_W*NUM_WORDS-1:0] r_s1_off;
  logic [CNT_W-1:0]           r_s1_count;
  logic                       r_s1_bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_tag    <= '0;
      r_s1_len    <= '0;
      r_s1_off    <= '0;
      r_s1_count  <= '0;
      r_s1_bypass <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_s1_data   <= in_data;
        r_s1_tag    <= w_tag_vec;
        r_s1_len    <= w_len_vec;
        r_s1_off    <= w_off_vec;
        r_s1_count  <= w_count;
        r_s1_bypass <= in_bypass;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 -> 2 (combinational): byte shifter
  // ---------------------------------------------------------------------------
  logic [LW-1:0] w_contrib [NUM_WORDS];
  logic [LW-1:0] w_or;
  logic [LW-1:0] w_pack;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_shift
    logic [31:0]      w_word;
    len_t             w_len;
    logic [CNT_W-1:0] w_off;
    logic [31:0]      w_kept;

    assign w_word = r_s1_data[32*gi +: 32];
    assign w_len  = r_s1_len[3*gi +: 3];
    assign w_off  = r_s1_off[CNT_W*gi +: CNT_W];

    // Drop the (4-k) zero low bytes so the kept bytes sit at the bottom in
    // their original relative order; k=0 shifts everything out.
    assign w_kept = w_word >> {LEN_FULL - w_len, 3'b000};

    // Place the kept bytes at the word's byte offset. Contributions never
    // overlap, so the packed line is a plain OR of all of them, and every
    // byte at or above the count stays zero.
    assign w_contrib[gi] = {{(LW-32){1'b0}}, w_kept} << {w_off, 3'b000};
  end : g_shift

  always_comb begin : p_or
    w_or = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      w_or = w_or | w_contrib[i];
    end
  end

  assign w_pack = r_s1_bypass ? r_s1_data : w_or;

  // ---------------------------------------------------------------------------
  // Stage 2 registers (output)
  // ---------------------------------------------------------------------------
  logic [LW-1:0]          r_out_data;
  logic [2*NUM_WORDS-1:0] r_out_tag;
  logic [CNT_W-1:0]       r_out_count;

  // Payload only loads when a real line moves in, so a stalled output keeps
  // presenting exactly the same line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_count <= '0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data  <= w_pack;
        r_out_tag   <= r_s1_tag;
        r_out_count <= r_s1_count;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign out_count = r_out_count;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] r_stat_lines;
  logic [STAT_W-1:0] r_stat_bytes;
  logic [STAT_W:0]   w_lines_inc;
  logic [STAT_W:0]   w_bytes_sum;

  // One extra bit catches overflow; on overflow the counter pins at all-ones.
  assign w_lines_inc = {1'b0, r_stat_lines} + (STAT_W+1)'(1);
  assign w_bytes_sum = {1'b0, r_stat_bytes} + (STAT_W+1)'(r_out_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_lines <= '0;
      r_stat_bytes <= '0;
    end else if (stat_clr) begin
      // Clear takes priority over a line leaving in the same cycle.
      r_stat_lines <= '0;
      r_stat_bytes <= '0;
    end else if (w_emit) begin
      r_stat_lines <= w_lines_inc[STAT_W] ? '1 : w_lines_inc[STAT_W-1:0];
      r_stat_bytes <= w_bytes_sum[STAT_W] ? '1 : w_bytes_sum[STAT_W-1:0];
    end
  end

  assign stat_lines = r_stat_lines;
  assign stat_bytes = r_stat_bytes;

endmodule

// File: tb/tb_word_pack_compressor.sv
// -----------------------------------------------------------------------------
// tb_word_pack_compressor
//   Directed bench for word_pack_compressor (NUM_WORDS=8, STAT_W=8 so the
//   saturating counters can be driven to all-ones in a short run).
// -----------------------------------------------------------------------------
module tb_word_pack_compressor;

  localparam int NW = 8;
  localparam int LW = 32 * NW;
  localparam int CW = 6;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_data;
  logic          in_bypass;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic [2*NW-1:0] out_tag;
  logic [CW-1:0] out_count;
  logic          stat_clr;
  logic [SW-1:0] stat_lines;
  logic [SW-1:0] stat_bytes;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed reference lines
  logic [LW-1:0]   t_data [4];
  logic [LW-1:0]   t_pack [4];
  logic [2*NW-1:0] t_tag  [4];
  logic [CW-1:0]   t_cnt  [4];

  word_pack_compressor #(
    .NUM_WORDS (NW),
    .STAT_W    (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_bypass  (in_bypass),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_count  (out_count),
    .stat_clr   (stat_clr),
    .stat_lines (stat_lines),
    .stat_bytes (stat_bytes)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0;
    out_ready = 1'b1; stat_clr = 1'b0;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", out_valid); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_data got=%0h exp=0", out_data); else n_pass++;
    n_checks++; if (out_tag !== '0) $display("FAIL reset_tag got=%0h exp=0", out_tag); else n_pass++;
    n_checks++; if (out_count !== '0) $display("FAIL reset_count got=%0d exp=0", out_count); else n_pass++;
    n_checks++; if (stat_lines !== '0 || stat_bytes !== '0) $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_lines, stat_bytes); else n_pass++;
    reset = 1'b0;
    step();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", in_ready); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_compress();
    in_data = t_data[0]; in_bypass = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL compress_latency1 got=%0h exp=0", out_valid); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL compress_valid got=%0h exp=1", out_valid); else n_pass++;
    n_checks++; if (out_tag !== t_tag[0]) $display("FAIL compress_tag got=%b exp=%b", out_tag, t_tag[0]); else n_pass++;
    n_checks++; if (out_count !== t_cnt[0]) $display("FAIL compress_count got=%0d exp=%0d", out_count, t_cnt[0]); else n_pass++;
    n_checks++; if (out_data !== t_pack[0]) $display("FAIL compress_data got=%h exp=%h", out_data, t_pack[0]); else n_pass++;
    $display("compress line: tag=%b count=%0d data=%h", out_tag, out_count, out_data);
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL compress_drain got=%0h exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_zero_bypass();
    logic [LW-1:0]   v_data, v_pack;
    logic            v_byp;
    logic [2*NW-1:0] v_tag;
    logic [CW-1:0]   v_cnt;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       begin v_data = '0;        v_byp = 1'b0; v_tag = 16'h0000; v_cnt = 6'd0;  v_pack = '0;        end
        1:       begin v_data = '0;        v_byp = 1'b1; v_tag = 16'hFFFF; v_cnt = 6'd32; v_pack = '0;        end
        default: begin v_data = t_data[0]; v_byp = 1'b1; v_tag = 16'hFFFF; v_cnt = 6'd32; v_pack = t_data[0]; end
      endcase
      in_data = v_data; in_bypass = v_byp; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_bypass = 1'b0;
      step();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL zb%0d_valid got=%0h exp=1", v, out_valid); else n_pass++;
      n_checks++; if (out_tag !== v_tag) $display("FAIL zb%0d_tag got=%h exp=%h", v, out_tag, v_tag); else n_pass++;
      n_checks++; if (out_count !== v_cnt) $display("FAIL zb%0d_count got=%0d exp=%0d", v, out_count, v_cnt); else n_pass++;
      n_checks++; if (out_data !== v_pack) $display("FAIL zb%0d_data got=%h exp=%h", v, out_data, v_pack); else n_pass++;
      $display("zero/bypass case %0d: tag=%h count=%0d", v, out_tag, out_count);
      step();
    end
  endtask

  task automatic test_back_to_back();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_checks++; if (stat_lines !== '0) $display("FAIL b2b_clr got=%0d exp=0", stat_lines); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b%0d_valid got=%0h exp=1", c-2, out_valid); else n_pass++;
        n_checks++; if (out_tag !== t_tag[c-2]) $display("FAIL b2b%0d_tag got=%h exp=%h", c-2, out_tag, t_tag[c-2]); else n_pass++;
        n_checks++; if (out_count !== t_cnt[c-2]) $display("FAIL b2b%0d_count got=%0d exp=%0d", c-2, out_count, t_cnt[c-2]); else n_pass++;
        n_checks++; if (out_data !== t_pack[c-2]) $display("FAIL b2b%0d_data got=%h exp=%h", c-2, out_data, t_pack[c-2]); else n_pass++;
        $display("b2b out %0d: tag=%h count=%0d", c-2, out_tag, out_count);
      end
      if (c < 4) begin
        in_valid = 1'b1; in_data = t_data[c];
        n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_in_ready got=%0h exp=1", c, in_ready); else n_pass++;
      end else begin
        in_valid = 1'b0; in_data = '0;
      end
      step();
    end
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%0h exp=0", out_valid); else n_pass++;
    n_checks++; if (stat_lines !== 8'd4) $display("FAIL b2b_stat_lines got=%0d exp=4", stat_lines); else n_pass++;
    n_checks++; if (stat_bytes !== 8'd71) $display("FAIL b2b_stat_bytes got=%0d exp=71", stat_bytes); else n_pass++;
  endtask

  task automatic test_stall();
    int n_acc = 0;
    int n_out = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = (n_acc < 3);
      in_data  = (n_acc < 3) ? t_data[n_acc+1] : '0;
      #1;
      if (out_valid === 1'b1) begin
        n_checks++; if (out_tag !== t_tag[1]) $display("FAIL stall%0d_tag got=%h exp=%h", cyc, out_tag, t_tag[1]); else n_pass++;
        n_checks++; if (out_count !== t_cnt[1]) $display("FAIL stall%0d_count got=%0d exp=%0d", cyc, out_count, t_cnt[1]); else n_pass++;
        n_checks++; if (out_data !== t_pack[1]) $display("FAIL stall%0d_data got=%h exp=%h", cyc, out_data, t_pack[1]); else n_pass++;
      end
      if (in_valid && in_ready) n_acc++;
      $display("stall cycle %0d: in_ready=%0h out_valid=%0h accepted=%0d", cyc, in_ready, out_valid, n_acc);
      step();
    end
    n_checks++; if (n_acc != 2) $display("FAIL stall_accepted got=%0d exp=2", n_acc); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%0h exp=0", in_ready); else n_pass++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (n_acc < 3);
      in_data  = (n_acc < 3) ? t_data[n_acc+1] : '0;
      #1;
      if (out_valid === 1'b1) begin
        if (n_out < 3) begin
          n_checks++; if (out_tag !== t_tag[n_out+1]) $display("FAIL drain%0d_tag got=%h exp=%h", n_out, out_tag, t_tag[n_out+1]); else n_pass++;
          n_checks++; if (out_count !== t_cnt[n_out+1]) $display("FAIL drain%0d_count got=%0d exp=%0d", n_out, out_count, t_cnt[n_out+1]); else n_pass++;
          n_checks++; if (out_data !== t_pack[n_out+1]) $display("FAIL drain%0d_data got=%h exp=%h", n_out, out_data, t_pack[n_out+1]); else n_pass++;
          $display("drain out %0d: tag=%h count=%0d", n_out, out_tag, out_count);
        end else begin
          n_checks++; $display("FAIL drain_extra got=line%0d exp=none", n_out);
        end
        n_out++;
      end
      if (in_valid && in_ready) n_acc++;
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (n_out != 3) $display("FAIL drain_lines got=%0d exp=3", n_out); else n_pass++;
    n_checks++; if (n_acc != 3) $display("FAIL drain_accepted got=%0d exp=3", n_acc); else n_pass++;
  endtask

  task automatic test_async_reset();
    int n_stale = 0;
    n_checks++; if (stat_lines !== 8'd7) $display("FAIL areset_pre_lines got=%0d exp=7", stat_lines); else n_pass++;
    n_checks++; if (stat_bytes !== 8'd127) $display("FAIL areset_pre_bytes got=%0d exp=127", stat_bytes); else n_pass++;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = t_data[0];
    step();
    in_data = t_data[1];
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL areset_inflight got=%0h exp=1", out_valid); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_valid got=%0h exp=0", out_valid); else n_pass++;
    n_checks++; if (stat_lines !== '0 || stat_bytes !== '0) $display("FAIL areset_stats got=%0d/%0d exp=0/0", stat_lines, stat_bytes); else n_pass++;
    n_checks++; if (out_count !== '0 || out_data !== '0) $display("FAIL areset_payload got=%0d/%h exp=0/0", out_count, out_data); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      if (out_valid !== 1'b0) n_stale++;
    end
    n_checks++; if (n_stale != 0) $display("FAIL areset_stale got=%0d exp=0", n_stale); else n_pass++;
    $display("async reset: stale outputs=%0d", n_stale);
  endtask

  task automatic test_stats();
    int  n_cons = 0;
    bit  mid_done = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = t_data[1];
    step();
    in_data = t_data[2];
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (stat_lines !== 8'd1 || stat_bytes !== 8'd8) $display("FAIL stats_one got=%0d/%0d exp=1/8", stat_lines, stat_bytes); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL stats_clr_emit got=%0h exp=1", out_valid); else n_pass++;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_checks++; if (stat_lines !== '0 || stat_bytes !== '0) $display("FAIL stats_clr_wins got=%0d/%0d exp=0/0", stat_lines, stat_bytes); else n_pass++;
    in_bypass = 1'b1; in_data = t_data[3];
    for (int i = 0; i < 264; i++) begin
      if (n_cons == 5 && !mid_done) begin
        mid_done = 1'b1;
        n_checks++; if (stat_lines !== 8'd5 || stat_bytes !== 8'd160) $display("FAIL stats_mid got=%0d/%0d exp=5/160", stat_lines, stat_bytes); else n_pass++;
      end
      if (out_valid === 1'b1) n_cons++;
      in_valid = (i < 260);
      step();
    end
    in_valid = 1'b0; in_bypass = 1'b0;
    n_checks++; if (n_cons != 260) $display("FAIL stats_emitted got=%0d exp=260", n_cons); else n_pass++;
    n_checks++; if (stat_lines !== 8'hFF) $display("FAIL stats_sat_lines got=%0d exp=255", stat_lines); else n_pass++;
    n_checks++; if (stat_bytes !== 8'hFF) $display("FAIL stats_sat_bytes got=%0d exp=255", stat_bytes); else n_pass++;
    $display("stats after %0d lines: lines=%0d bytes=%0d", n_cons, stat_lines, stat_bytes);
  endtask

  initial begin
    t_data[0] = 256'h12000000_00000000_34000000_56780000_9ABCDEF1_23000000_45670000_89ABCDEF;
    t_tag[0]  = 16'b0100011011011011;
    t_cnt[0]  = 6'd15;
    t_pack[0] = 256'h12_34_5678_9ABCDEF1_23_4567_89ABCDEF;

    t_data[1] = {8{32'hAB000000}};
    t_tag[1]  = 16'h5555;
    t_cnt[1]  = 6'd8;
    t_pack[1] = 256'hABABABAB_ABABABAB;

    t_data[2] = {8{32'hCDEF0000}};
    t_tag[2]  = 16'hAAAA;
    t_cnt[2]  = 6'd16;
    t_pack[2] = {128'h0, {8{16'hCDEF}}};

    t_data[3] = 256'h00112233_44556677_8899AABB_CCDDEEFF_FEDCBA98_76543210_0F1E2D3C_4B5A6978;
    t_tag[3]  = 16'hFFFF;
    t_cnt[3]  = 6'd32;
    t_pack[3] = t_data[3];

    test_reset();
    test_compress();
    test_zero_bypass();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_stats();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
